// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary conversions.
// The functions work on 32-bit vectors; callers size-cast to their pointer width.
package fifo_pkg;

    localparam int ADDRSIZE_DEF   = 4;
    localparam int DATAWIDTH_DEF  = 8;
    localparam int AEMPTY_THR_DEF = 2;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle: synchronised write pointer, memory read port and consumer handshake.
// master = the read controller, slave = memory/synchroniser/consumer around it.
interface fifo_rd_ctrl_if
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = ADDRSIZE_DEF,
    parameter int DATAWIDTH = DATAWIDTH_DEF
);

    logic [ADDRSIZE:0]    rq2_wptr;
    logic [DATAWIDTH-1:0] rMEMDATA;
    logic                 rREADY;
    logic [ADDRSIZE-1:0]  rADDR;
    logic [ADDRSIZE:0]    rPTR;
    logic                 rEMPTY;
    logic                 rAEMPTY;
    logic [ADDRSIZE:0]    rLEVEL;
    logic [DATAWIDTH-1:0] rDATA;
    logic                 rVALID;

    modport master (
        input  rq2_wptr, rMEMDATA, rREADY,
        output rADDR, rPTR, rEMPTY, rAEMPTY, rLEVEL, rDATA, rVALID
    );

    modport slave (
        output rq2_wptr, rMEMDATA, rREADY,
        input  rADDR, rPTR, rEMPTY, rAEMPTY, rLEVEL, rDATA, rVALID
    );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
// Zero latency, no state.
module fifo_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        assign bin[i] = ^gray[W-1:i];
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async-FIFO read controller: Gray/binary read pointers, empty/almost-empty/level flags, FWFT output register.
// Latency: non-empty seen on edge N, word presented in rDATA after edge N+1; one word per cycle while rREADY=1.
// Backpressure: rVALID && !rREADY freezes rDATA and the read pointer.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE   = ADDRSIZE_DEF,
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int AEMPTY_THR = AEMPTY_THR_DEF
) (
    input  logic           rCLK,
    input  logic           rRST,
    fifo_rd_ctrl_if.master bus
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [PW-1:0] THR = PW'(AEMPTY_THR);

    logic [PW-1:0]        rbin;
    logic [PW-1:0]        rbin_next;
    logic [PW-1:0]        rgray_next;
    logic [PW-1:0]        wbin_s;
    logic [PW-1:0]        level_next;
    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        level_q;
    logic                 empty_q;
    logic                 aempty_q;
    logic                 valid_q;
    logic [DATAWIDTH-1:0] data_q;
    logic                 pop;

    fifo_gray2bin #(.W(PW)) u_wptr_g2b (
        .gray (bus.rq2_wptr),
        .bin  (wbin_s)
    );

    // Pop uses the registered empty flag, so a freshly synchronised write pointer costs one cycle.
    assign pop        = !empty_q && (!valid_q || bus.rREADY);
    assign rbin_next  = rbin + PW'(pop);
    assign rgray_next = PW'(bin2gray(32'(rbin_next)));
    assign level_next = wbin_s - rbin_next;

    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            rbin     <= '0;
            ptr_q    <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            level_q  <= '0;
        end else begin
            rbin     <= rbin_next;
            ptr_q    <= rgray_next;
            empty_q  <= (rgray_next == bus.rq2_wptr);
            aempty_q <= (level_next <= THR);
            level_q  <= level_next;
        end
    end

    always_ff @(posedge rCLK or posedge rRST) begin
        if (rRST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (pop) begin
            valid_q <= 1'b1;
            data_q  <= bus.rMEMDATA;
        end else if (bus.rREADY) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.rADDR   = rbin[ADDRSIZE-1:0];
    assign bus.rPTR    = ptr_q;
    assign bus.rEMPTY  = empty_q;
    assign bus.rAEMPTY = aempty_q;
    assign bus.rLEVEL  = level_q;
    assign bus.rDATA   = data_q;
    assign bus.rVALID  = valid_q;

    a_hold_under_backpressure: assert property (
        @(posedge rCLK) disable iff (rRST)
        (valid_q && !bus.rREADY) |=> (valid_q && $stable(data_q))
    );

    a_empty_means_no_level: assert property (
        @(posedge rCLK) disable iff (rRST)
        empty_q |-> (level_q == '0)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: vector table, directed corner sequences, then random traffic vs a count-based model.
module tb_fifo_rd_ctrl;

    logic rCLK = 1'b0;
    logic rRST = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 rCLK = ~rCLK;

    fifo_rd_ctrl_if #(.ADDRSIZE(4), .DATAWIDTH(8)) bus ();

    assign bus.rMEMDATA = 8'hA0 + {4'h0, bus.rADDR};

    fifo_rd_ctrl #(.ADDRSIZE(4), .DATAWIDTH(8), .AEMPTY_THR(2)) dut (
        .rCLK (rCLK),
        .rRST (rRST),
        .bus  (bus)
    );

    typedef struct {
        bit         rst;
        int         wcnt;
        bit         rdy;
        bit         valid;
        logic [7:0] data;
        bit         empty;
        bit         aempty;
        logic [4:0] level;
        logic [3:0] addr;
        logic [4:0] ptr;
    } vec_t;

    function automatic logic [4:0] gray(input int n);
        logic [4:0] b;
        b = 5'(n % 32);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge rCLK);
        #1;
    endtask

    task automatic check_all(input string tag, input bit valid, input logic [7:0] data,
                             input bit empty, input bit aempty, input logic [4:0] level,
                             input logic [3:0] addr, input logic [4:0] ptr);
        chk({tag, ".valid"},  32'(bus.rVALID),  32'(valid));
        chk({tag, ".data"},   32'(bus.rDATA),   32'(data));
        chk({tag, ".empty"},  32'(bus.rEMPTY),  32'(empty));
        chk({tag, ".aempty"}, 32'(bus.rAEMPTY), 32'(aempty));
        chk({tag, ".level"},  32'(bus.rLEVEL),  32'(level));
        chk({tag, ".addr"},   32'(bus.rADDR),   32'(addr));
        chk({tag, ".ptr"},    32'(bus.rPTR),    32'(ptr));
    endtask

    task automatic do_reset();
        rRST = 1'b1;
        bus.rq2_wptr = '0;
        bus.rREADY = 1'b0;
        step();
        rRST = 1'b0;
    endtask

    vec_t vt[$];
    int   wcnt;
    int   m_rcnt;
    bit   m_valid;
    bit   m_empty;
    logic [7:0] m_data;
    int   lvl;
    bit   rdy;
    bit   pop;
    bit   seen_wrap;
    bit   seen_ptr16;
    logic [3:0] prev_addr;

    initial begin
        bus.rq2_wptr = '0;
        bus.rREADY   = 1'b0;

        // Asynchronous reset between edges must act without a clock.
        #13 rRST = 1'b1;
        #1;
        check_all("arst", 1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 4'd0, 5'b00000);
        step();
        rRST = 1'b0;

        // Single word with no consumer, then a 5-word stream at full rate.
        vt.push_back('{1, 0, 0, 0, 8'h00, 1, 1, 5'd0, 4'd0, 5'b00000});
        vt.push_back('{0, 1, 0, 0, 8'h00, 0, 1, 5'd1, 4'd0, 5'b00000});
        vt.push_back('{0, 1, 0, 1, 8'hA0, 1, 1, 5'd0, 4'd1, 5'b00001});
        for (int i = 0; i < 5; i++)
            vt.push_back('{0, 1, 0, 1, 8'hA0, 1, 1, 5'd0, 4'd1, 5'b00001});
        vt.push_back('{1, 0, 0, 0, 8'h00, 1, 1, 5'd0, 4'd0, 5'b00000});
        vt.push_back('{0, 5, 1, 0, 8'h00, 0, 0, 5'd5, 4'd0, 5'b00000});
        vt.push_back('{0, 5, 1, 1, 8'hA0, 0, 0, 5'd4, 4'd1, 5'b00001});
        vt.push_back('{0, 5, 1, 1, 8'hA1, 0, 0, 5'd3, 4'd2, 5'b00011});
        vt.push_back('{0, 5, 1, 1, 8'hA2, 0, 1, 5'd2, 4'd3, 5'b00010});
        vt.push_back('{0, 5, 1, 1, 8'hA3, 0, 1, 5'd1, 4'd4, 5'b00110});
        vt.push_back('{0, 5, 1, 1, 8'hA4, 1, 1, 5'd0, 4'd5, 5'b00111});
        vt.push_back('{0, 5, 1, 0, 8'hA4, 1, 1, 5'd0, 4'd5, 5'b00111});

        for (int i = 0; i < vt.size(); i++) begin
            rRST = vt[i].rst;
            bus.rq2_wptr = gray(vt[i].wcnt);
            bus.rREADY = vt[i].rdy;
            step();
            check_all($sformatf("vec%0d", i), vt[i].valid, vt[i].data, vt[i].empty,
                      vt[i].aempty, vt[i].level, vt[i].addr, vt[i].ptr);
            rRST = 1'b0;
        end

        // Backpressure: 4 written, one popped into the output register, consumer stalls.
        do_reset();
        bus.rq2_wptr = gray(4);
        step();
        step();
        check_all("bp.first", 1'b1, 8'hA0, 1'b0, 1'b0, 5'd3, 4'd1, 5'b00001);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("bp.hold%0d", i), 1'b1, 8'hA0, 1'b0, 1'b0, 5'd3, 4'd1, 5'b00001);
        end
        bus.rREADY = 1'b1;
        step();
        check_all("bp.r1", 1'b1, 8'hA1, 1'b0, 1'b1, 5'd2, 4'd2, 5'b00011);
        step();
        check_all("bp.r2", 1'b1, 8'hA2, 1'b0, 1'b1, 5'd1, 4'd3, 5'b00010);
        step();
        check_all("bp.r3", 1'b1, 8'hA3, 1'b1, 1'b1, 5'd0, 4'd4, 5'b00110);
        step();
        chk("bp.drain.valid", 32'(bus.rVALID), 32'd0);

        // Reset mid-stream after two words have been delivered.
        do_reset();
        bus.rq2_wptr = gray(5);
        bus.rREADY = 1'b1;
        step();
        step();
        step();
        chk("mid.pre.data", 32'(bus.rDATA), 32'hA1);
        #3 rRST = 1'b1;
        #1;
        check_all("mid.arst", 1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 4'd0, 5'b00000);
        bus.rq2_wptr = '0;
        step();
        rRST = 1'b0;
        step();
        step();
        check_all("mid.after", 1'b0, 8'h00, 1'b1, 1'b1, 5'd0, 4'd0, 5'b00000);

        // Random traffic against a model built on word counts.
        do_reset();
        wcnt = 0;
        m_rcnt = 0;
        m_valid = 1'b0;
        m_empty = 1'b1;
        m_data = 8'h00;
        seen_wrap = 1'b0;
        seen_ptr16 = 1'b0;
        prev_addr = 4'd0;
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0 && (wcnt - m_rcnt) < 16)
                wcnt++;
            bus.rq2_wptr = gray(wcnt);
            bus.rREADY = rdy;
            step();
            pop = !m_empty && (!m_valid || rdy);
            if (pop) begin
                m_data  = 8'hA0 + 8'(m_rcnt % 16);
                m_valid = 1'b1;
                m_rcnt++;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            lvl = (wcnt - m_rcnt) % 32;
            m_empty = (lvl == 0);
            check_all($sformatf("rnd%0d", c), m_valid, m_data, m_empty, (lvl <= 2),
                      5'(lvl), 4'(m_rcnt % 16), gray(m_rcnt));
            if (prev_addr == 4'd15 && bus.rADDR == 4'd0)
                seen_wrap = 1'b1;
            if (bus.rPTR == 5'b11000)
                seen_ptr16 = 1'b1;
            prev_addr = bus.rADDR;
        end
        chk("rnd.addr_wrapped", 32'(seen_wrap), 32'd1);
        chk("rnd.ptr_passed_16", 32'(seen_ptr16), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller of the asynchronous FIFO, running entirely in the read clock domain.
- Keeps the binary and Gray read pointers and drives the memory read address.
- Derives empty, almost-empty and fill level from the write pointer after it has been synchronised into this domain.
- Presents a first-word-fall-through output register with a valid/ready handshake to the consumer.
- Sits between the dual-port FIFO memory (combinational read port), the 2-FF write-to-read pointer synchroniser, and the consuming logic.

Parameters:
ADDRSIZE, 4, memory address width; depth = 2**ADDRSIZE.
DATAWIDTH, 8, data word width.
AEMPTY_THR, 2, rAEMPTY asserts when memory words remaining <= this value.

Ports:
rCLK  in  1  read-domain clock; single clock for the whole block.
rRST  in  1  asynchronous, active-high reset.
rq2_wptr  in  ADDRSIZE+1  Gray write pointer, already 2-FF synchronised into rCLK.
rMEMDATA  in  DATAWIDTH  memory read data at rADDR (combinational read).
rREADY  in  1  consumer accepts rDATA this cycle.
rADDR  out  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0].
rPTR  out  ADDRSIZE+1  registered Gray read pointer, to the read-to-write synchroniser.
rEMPTY  out  1  registered; memory holds no unread word.
rAEMPTY  out  1  registered almost-empty flag.
rLEVEL  out  ADDRSIZE+1  registered count of words in memory, excluding the word held in the output register.
rDATA  out  DATAWIDTH  output data register.
rVALID  out  1  rDATA holds a valid word.

Behaviour:
- Reset (rRST=1, asynchronous, takes effect without a clock edge):
  - rbin=0, rPTR=0, rADDR=0.
  - rEMPTY=1, rAEMPTY=1, rLEVEL=0.
  - rVALID=0, rDATA=0.
- Pop condition: pop = !rEMPTY && (!rVALID || rREADY). rEMPTY here is the registered flag.
- On pop:
  - rDATA <= rMEMDATA, rVALID <= 1.
  - rbin_next = rbin + 1, wrapping modulo 2**(ADDRSIZE+1).
- Else if rREADY: rVALID <= 0.
- Else: rDATA and rVALID hold.
- Gray pointer:
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - rPTR <= rgray_next on the same edge that rbin updates, so rPTR never lags rbin.
- Empty: rEMPTY <= (rgray_next == rq2_wptr). It asserts on the same edge as the pop that takes the last word, so there is no underflow window.
- Level:
  - wbin_s = gray-to-binary(rq2_wptr).
  - rLEVEL <= (wbin_s - rbin_next), computed modulo 2**(ADDRSIZE+1).
  - rAEMPTY <= (that value <= AEMPTY_THR).
- Latency:
  - rq2_wptr changes from empty to non-empty before edge N; rEMPTY=0 after edge N.
  - Pop occurs on edge N+1: rVALID=1, rDATA=mem[rADDR].
- Throughput: with rREADY held at 1, one word per cycle with no bubbles.
- Handshake rules:
  - A transfer occurs when rVALID && rREADY.
  - rREADY while !rVALID is ignored and pops only if memory is non-empty.
  - rDATA is stable while rVALID && !rREADY.
- Wrap-around:
  - The pointer MSB toggles each pass through memory; rADDR wraps 2**ADDRSIZE-1 -> 0.
  - Empty compares all ADDRSIZE+1 bits.
- Simultaneous events: a pop and an rq2_wptr change in the same cycle are evaluated together, using rbin_next and the current rq2_wptr.
- Reset mid-operation: the word in the output register is discarded and the pointers return to 0. The writer side must be reset together with this block.

Decomposition:
- Shared package fifo_pkg holds:
  - default ADDRSIZE and DATAWIDTH constants;
  - bin2gray and gray2bin functions, also used by the write side.
- One sub-module: fifo_gray2bin (parameterised width, combinational XOR-prefix), instantiated for rq2_wptr.
- Output-stage and pointer logic stay in fifo_rd_ctrl.

Test Plan:
All scenarios use ADDRSIZE=4, DATAWIDTH=8, AEMPTY_THR=2, and a memory model with mem[i]=8'hA0+i.
1. Reset: assert rRST between clock edges -> all outputs at reset values immediately (rEMPTY=1, rAEMPTY=1, rVALID=0, rPTR=5'b00000).
2. Single word: rq2_wptr=5'b00001, rREADY=0 -> next edge rEMPTY=0, rLEVEL=1; following edge rVALID=1, rDATA=8'hA0, rADDR=1, rPTR=5'b00001, rEMPTY=1, rLEVEL=0; rVALID and rDATA hold for 5 cycles.
3. Streaming: rq2_wptr=gray(5)=5'b00111, rREADY=1 -> rDATA A0,A1,A2,A3,A4 on 5 consecutive cycles; rAEMPTY rises when rLEVEL drops to 2; rVALID=0 on the cycle after A4 is accepted.
4. Backpressure: 3 words in memory, rVALID=1, rREADY=0 -> rADDR, rPTR, rLEVEL and rDATA unchanged; releasing rREADY resumes one word per cycle.
5. Wrap: stream 20 words, rq2_wptr advancing ahead of reads -> rADDR goes 15 -> 0, rPTR passes gray(16)=5'b11000, data continues A0.. from mem[0]; rEMPTY=1 exactly when rPTR == rq2_wptr.
6. Reset mid-stream: pulse rRST during scenario 3 after 2 words -> rVALID=0 and rbin=0 immediately; after release with rq2_wptr=0, rEMPTY=1 and no pop occurs.
